// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned RD_BITS       = 5;
  localparam int unsigned F3_BITS       = 3;
  localparam int unsigned MEM_BYTES_DEF = 4096;

  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // Operation latched on acceptance; its address/funct3/wdata fields drive the memory port.
  typedef struct packed {
    logic               we;
    logic [F3_BITS-1:0] funct3;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
    logic [RD_BITS-1:0] rd;
  } lsu_op_t;

endpackage

// File: rtl/lsu_align_check.sv
// Flags illegal funct3, misaligned halfword/word and out-of-range addresses.
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic               we,
  input  logic [F3_BITS-1:0] funct3,
  input  logic [XLEN-1:0]    addr,
  output logic               err_c
);

  logic bad_f3;
  logic bad_half;
  logic bad_word;
  logic bad_range;

  always_comb begin
    bad_f3    = 1'b0;
    bad_half  = 1'b0;
    bad_word  = 1'b0;
    bad_range = 1'b0;
    if (we) begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    bad_half  = (funct3 == F3_H || funct3 == F3_HU) && addr[0];
    bad_word  = (funct3 == F3_W) && (addr[1:0] != 2'b00);
    bad_range = addr >= XLEN'(MEM_BYTES);
    err_c     = bad_f3 | bad_half | bad_word | bad_range;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a registered data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [F3_BITS-1:0] req_funct3,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  input  logic [RD_BITS-1:0] req_rd,
  output logic [XLEN-1:0]    mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [F3_BITS-1:0] mem_funct3,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_data,
  output logic [RD_BITS-1:0] rsp_rd,
  output logic               rsp_err
);

  lsu_state_e         state;
  lsu_state_e         state_next;
  lsu_op_t            op;
  lsu_op_t            op_d;
  logic               err_c;
  logic               req_ready_d;
  logic               mem_read_d;
  logic               mem_write_d;
  logic               rsp_valid_d;
  logic               rsp_err_d;
  logic [XLEN-1:0]    rsp_data_d;
  logic [RD_BITS-1:0] rsp_rd_d;

  lsu_align_check #(.MEM_BYTES(MEM_BYTES)) u_align_check (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .err_c  (err_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = err_c ? RESP : ACCESS;
      ACCESS:  state_next = op.we ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    op_d        = op;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_data_d  = rsp_data;
    rsp_rd_d    = rsp_rd;
    req_ready_d = (state_next == IDLE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_d = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata, rd: req_rd};
          if (err_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_rd_d    = req_rd;
          end else begin
            mem_read_d  = !req_we;
            mem_write_d = req_we;
          end
        end
      end
      ACCESS: begin
        if (op.we) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_rd_d    = op.rd;
        end
      end
      CAPTURE: begin
        // Memory already applied sign/zero extension; pass the word through.
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = mem_rdata;
        rsp_rd_d    = op.rd;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_rd_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and operation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      req_ready <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
    end else begin
      op        <= op_d;
      req_ready <= req_ready_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      rsp_rd    <= rsp_rd_d;
    end
  end

  assign mem_addr   = op.addr;
  assign mem_funct3 = op.funct3;
  assign mem_wdata  = op.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array data memory.
module tb_load_store_unit;

  localparam int unsigned MEMB = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  load_store_unit #(.MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Environment data memory: registered read with extension, byte-lane writes
  logic [7:0] dmem [MEMB];
  bit         dmem_init = 1'b0;
  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int i = 0; i < int'(MEMB); i++) dmem[i] <= init_byte(i);
      dmem_init <= 1'b1;
    end else begin
      if (mem_write) begin
        for (int b = 0; b < (1 << mem_funct3[1:0]); b++)
          dmem[(int'(mem_addr) + b) % MEMB] <= mem_wdata[8*b +: 8];
      end
      if (mem_read) begin
        mem_rdata <= load_ext(mem_funct3, {dmem[(int'(mem_addr) + 3) % MEMB], dmem[(int'(mem_addr) + 2) % MEMB],
                                           dmem[(int'(mem_addr) + 1) % MEMB], dmem[int'(mem_addr) % MEMB]});
      end
    end
  end

  // Reference model state: memory image as the pipeline sees it
  logic [7:0] refm [MEMB];

  typedef struct {
    int          acc;
    int          lat;
    bit          err;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } exp_t;

  exp_t exp_q[$];
  bit   bp_mode = 1'b0;

  function automatic bit ref_is_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    size = 1 << f3[1:0];
    if (addr % size != 0) return 1'b1;
    return addr >= MEMB;
  endfunction

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, output int waited);
    exp_t e;
    logic [31:0] w;
    waited = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    while (!req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    e.acc = cyc; e.rd = rd; e.we = we; e.addr = addr; e.wdata = wdata; e.f3 = f3;
    e.err = ref_is_err(we, f3, addr);
    e.data = 32'h0;
    if (e.err) e.lat = 1;
    else if (we) begin
      e.lat = 2;
      for (int b = 0; b < (1 << f3[1:0]); b++) refm[int'(addr) + b] = wdata[8*b +: 8];
    end else begin
      e.lat = 3;
      w = 32'h0;
      for (int b = 0; b < (1 << f3[1:0]); b++) w[8*b +: 8] = refm[int'(addr) + b];
      e.data = load_ext(f3, w);
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: strobe observation, response checking, backpressure hold and stability
  int          n_rd = 0, n_wr = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [2:0]  obs_f3;
  bit          active = 1'b0, idle_chk = 1'b0;
  int          held = 0, hold_target = 0;
  logic [31:0] snap_data;
  logic [4:0]  snap_rd;
  logic        snap_err;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      n_rd = 0; n_wr = 0; active = 1'b0; idle_chk = 1'b0; rsp_ready = 1'b1;
    end else begin
      if (idle_chk) begin
        check("idle_after_consume", 32'(req_ready), 32'd1);
        idle_chk = 1'b0;
      end
      if (mem_read && mem_write) check("both_strobes", 32'd1, 32'd0);
      if (mem_read || mem_write) begin
        if (mem_read) n_rd++;
        if (mem_write) n_wr++;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_f3 = mem_funct3;
      end
      if (rsp_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_data", rsp_data, e.data);
            check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
            check("n_read", 32'(n_rd), (e.err || e.we) ? 32'd0 : 32'd1);
            check("n_write", 32'(n_wr), (!e.err && e.we) ? 32'd1 : 32'd0);
            if (!e.err) begin
              check("mem_addr", obs_addr, e.addr);
              check("mem_funct3", 32'(obs_f3), 32'(e.f3));
              if (e.we) check("mem_wdata", obs_wdata, e.wdata);
            end
          end
          n_rd = 0; n_wr = 0;
          active = 1'b1; held = 0;
          hold_target = bp_mode ? 5 : int'($urandom_range(0, 2));
          snap_data = rsp_data; snap_rd = rsp_rd; snap_err = rsp_err;
        end else begin
          check("hold_data", rsp_data, snap_data);
          check("hold_rd_err", {26'h0, rsp_err, rsp_rd}, {26'h0, snap_err, snap_rd});
        end
        check("ready_in_resp", 32'(req_ready), 32'd0);
        rsp_ready = (held >= hold_target);
        if (!rsp_ready) held++;
        else begin
          active = 1'b0;
          idle_chk = 1'b1;
        end
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || active || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < int'(MEMB); i++) refm[i] = init_byte(i);

    // Reset state
    @(negedge clk);
    check("reset_outs", {rsp_valid, rsp_err, rsp_rd, mem_read, mem_write, mem_funct3} , 32'h0);
    check("reset_buses", rsp_data | mem_addr | mem_wdata, 32'h0);
    check("reset_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Directed: store word, signed and unsigned byte loads
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, w);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd2, w);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, w);
    // Error cases
    issue(1'b0, 3'b001, 32'h101, 32'h0, 5'd4, w);
    issue(1'b1, 3'b010, 32'h102, 32'h12345678, 5'd5, w);
    issue(1'b0, 3'b000, 32'h1000, 32'h0, 5'd6, w);
    issue(1'b1, 3'b000, 32'h1000, 32'h55, 5'd7, w);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd8, w);
    issue(1'b1, 3'b100, 32'h100, 32'h0, 5'd9, w);
    issue(1'b0, 3'b010, 32'hFFC, 32'h0, 5'd10, w);
    drain();

    // Backpressure: five cycles of rsp_ready low on a word load
    bp_mode = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd11, w);
    drain();
    bp_mode = 1'b0;

    // Reset during CAPTURE of a load
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd12, w);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {rsp_valid, rsp_err, rsp_rd, mem_read, mem_write, mem_funct3}, 32'h0);
    check("midrst_buses", rsp_data | mem_addr | mem_wdata, 32'h0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 3'b001, 32'h202, 32'h0000A5C3, 5'd13, w);
    check("accept_after_reset_wait", 32'(w), 32'd0);
    issue(1'b0, 3'b001, 32'h202, 32'h0, 5'd14, w);
    issue(1'b0, 3'b101, 32'h202, 32'h0, 5'd15, w);

    // Random traffic on a small window plus occasional out-of-range addresses
    for (int i = 0; i < 200; i++) begin
      we = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 0 : 4) * 1);
      if (f3 == 3'b110) f3 = 3'b100;
      if ($urandom_range(0, 9) == 0) a = 32'(MEMB) + 32'($urandom_range(0, 300)) - 32'd4;
      else a = 32'h300 + 32'($urandom_range(0, 31));
      issue(we, f3, a, $urandom, 5'($urandom_range(0, 31)), w);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
